// File: rtl/rio_uart_bridge.sv
// ----------------------------------------------------------------------------
// rio_uart_bridge
//
// Host-side UART bridge for the prelude core's register I/O port. Bytes the
// core writes to rio_out are serialized onto uart_tx (8N1, LSB first). Bytes
// arriving on uart_rx are deserialized into rio_in for the core to read.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4, even)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   rio_out[7:0]  byte from the core's I/O output register
//   rio_wr        one-cycle write strobe, rio_out valid this cycle
//   rio_in[7:0]   last good received byte
//   rx_valid      unread byte present in rio_in
//   rx_ack        one-cycle strobe, core consumed rio_in
//   uart_rx       serial input (asynchronous to clk)
//   uart_tx       serial output, idle high
//   tx_busy       shifter or holding register occupied
//   tx_overrun    sticky, a write was dropped
//   rx_overrun    sticky, a byte arrived while rx_valid was set
//   rx_frame_err  one-cycle pulse, stop bit sampled low
// ----------------------------------------------------------------------------
module rio_uart_bridge #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rio_out,
    input  logic       rio_wr,
    output logic [7:0] rio_in,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_overrun,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_hold_q, tx_hold_d;
    logic          tx_hold_full_q, tx_hold_full_d;
    logic          tx_ovr_q, tx_ovr_d;
    logic          tx_tick;
    logic          tx_stop_end;

    assign tx_tick     = (tx_cnt_q == BIT_LAST);
    assign tx_stop_end = (tx_state_q == TX_STOP) && tx_tick;

    always_comb begin
        tx_state_d     = tx_state_q;
        tx_cnt_d       = tx_cnt_q;
        tx_bit_d       = tx_bit_q;
        tx_shift_d     = tx_shift_q;
        tx_hold_d      = tx_hold_q;
        tx_hold_full_d = tx_hold_full_q;
        tx_ovr_d       = tx_ovr_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (rio_wr) begin
                    tx_shift_d = rio_out;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    if (tx_hold_full_q) begin
                        tx_shift_d     = tx_hold_q;
                        tx_hold_full_d = 1'b0;
                        tx_state_d     = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Writes while busy. On the final stop cycle a slot is freed in the
        // same cycle: with an empty holding register the write goes straight
        // into the shifter (zero gap); with a full one it refills the holding
        // register as its old byte moves into the shifter.
        if (rio_wr && (tx_state_q != TX_IDLE)) begin
            if (tx_stop_end && !tx_hold_full_q) begin
                tx_shift_d = rio_out;
                tx_state_d = TX_START;
            end else if (!tx_hold_full_q || tx_stop_end) begin
                tx_hold_d      = rio_out;
                tx_hold_full_d = 1'b1;
            end else begin
                tx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q     <= TX_IDLE;
            tx_cnt_q       <= '0;
            tx_bit_q       <= '0;
            tx_shift_q     <= '0;
            tx_hold_q      <= '0;
            tx_hold_full_q <= 1'b0;
            tx_ovr_q       <= 1'b0;
        end else begin
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_bit_q       <= tx_bit_d;
            tx_shift_q     <= tx_shift_d;
            tx_hold_q      <= tx_hold_d;
            tx_hold_full_q <= tx_hold_full_d;
            tx_ovr_q       <= tx_ovr_d;
        end
    end

    // Line level is decoded from state so reset forces it high immediately.
    always_comb begin
        uart_tx = 1'b1;
        if (tx_state_q == TX_START) begin
            uart_tx = 1'b0;
        end else if (tx_state_q == TX_DATA) begin
            uart_tx = tx_shift_q[0];
        end
    end

    assign tx_busy    = (tx_state_q != TX_IDLE) || tx_hold_full_q;
    assign tx_overrun = tx_ovr_q;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic          rx_meta_q, rx_sync_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rio_in_q, rio_in_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_good;
    logic          rx_tick;

    assign rx_tick = (rx_cnt_q == BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rio_in_d   = rio_in_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = 1'b0;
        rx_good    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START_CHK;
                end
            end
            RX_START_CHK: begin
                // Half-bit delay places all later samples at mid-bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_good    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                // Hold off until the line idles so a low line is not
                // mistaken for a fresh start bit.
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A byte landing together with rx_ack replaces the acked byte, so
        // rx_valid stays set and no overrun is flagged.
        if (rx_good) begin
            rio_in_d   = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                rx_ovr_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rio_in_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rio_in_q   <= rio_in_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rio_in       = rio_in_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_ovr_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: doc/rio_uart_bridge.md
# rio_uart_bridge

Host-side UART bridge for the prelude core's register I/O port. It serializes each byte the core writes to `rio_out` onto `uart_tx`, 8N1, LSB first. It deserializes bytes arriving on `uart_rx` into the value the core reads on `rio_in`. It sits between the core and the board UART pins and gives the core a host link without changing the instruction set.

## Interface
Parameters:
- `CLKS_PER_BIT`, 234, clock cycles per UART bit (27 MHz / 115200). Must be ≥ 4 and even.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rio_out`  in  8  byte from the core's I/O output register.
- `rio_wr`  in  1  one-cycle pulse: core wrote the I/O register; `rio_out` is valid this cycle.
- `rio_in`  out  8  last good received byte, fed to the core's I/O input.
- `rx_valid`  out  1  unread byte present in `rio_in`.
- `rx_ack`  in  1  one-cycle pulse: core consumed `rio_in`.
- `uart_rx`  in  1  serial input, asynchronous to `clk`.
- `uart_tx`  out  1  serial output, idle high.
- `tx_busy`  out  1  shifter or holding register occupied.
- `tx_overrun`  out  1  sticky: a write was dropped.
- `rx_overrun`  out  1  sticky: a byte arrived while `rx_valid` was 1.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Reset values: `uart_tx`=1, `tx_busy`=0, `rio_in`=8'h00, `rx_valid`=0, `tx_overrun`=0, `rx_overrun`=0, `rx_frame_err`=0. Both FSMs return to IDLE. Reset mid-frame aborts the frame immediately; `uart_tx` goes high asynchronously.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE, or → START if the holding register is full. Each state or bit lasts exactly `CLKS_PER_BIT` cycles.
- TX buffering: one shifter plus a one-byte holding register.
  - `rio_wr` in IDLE loads the shifter.
  - `rio_wr` while the shifter is busy and the holding register is empty loads the holding register.
  - `rio_wr` while both are full drops the byte and sets `tx_overrun`.
  - A write that frees a slot in the same cycle is accepted, not dropped.
- RX synchronizer: `uart_rx` passes through 2 flops; all RX logic uses the synced value.
- RX FSM: IDLE → START_CHK → DATA → STOP → IDLE.
  - IDLE: a synced low starts a `CLKS_PER_BIT/2` count.
  - START_CHK: the line is re-sampled at the end of the count. Low confirms the start bit. High is a glitch: return to IDLE with no outputs changed.
  - DATA: 8 samples, one every `CLKS_PER_BIT` cycles (mid-bit), shifted in LSB first.
  - STOP: the stop bit is sampled mid-bit.
- Good stop (high): `rio_in` is loaded with the byte and `rx_valid` is set.
- Bad stop (low): `rx_frame_err` pulses for one cycle and `rio_in`/`rx_valid` are unchanged. The FSM waits for the synced line to be high before re-entering IDLE.
- `rx_ack` clears `rx_valid`. `rx_ack` with `rx_valid`=0 has no effect.
- A good byte arriving with `rx_valid`=1 and no `rx_ack` in the same cycle:
  - overwrites `rio_in`;
  - sets `rx_overrun`;
  - leaves `rx_valid` at 1.
- A good byte coinciding with `rx_ack` leaves `rx_valid`=1 and does not set `rx_overrun`.
- Sticky flags clear only on `rst`.

## Timing
- TX latency: `rio_wr` in IDLE at cycle N → `uart_tx` low from cycle N+1. `tx_busy` is high from N+1.
- One frame lasts 10×`CLKS_PER_BIT` cycles. Back-to-back held bytes have zero idle gap: the next start bit begins the cycle after the stop bit's last cycle.
- `tx_busy` falls the cycle after the final stop-bit cycle when the holding register is empty.
- RX latency: the line's falling edge reaches the FSM 2 cycles later (synchronizer).
- `rio_in`/`rx_valid` update on the cycle after the stop-bit mid sample. `rx_frame_err` pulses in that same cycle instead on a bad stop.
- `rx_ack` takes effect on the next rising edge. `rx_valid` reads 0 the following cycle.

## Test plan
Use `CLKS_PER_BIT`=8 for all scenarios.
- TX single: `rio_wr` with 8'hA5 at cycle 10 → `uart_tx` = 0,1,0,1,0,0,1,0,1,1 in 8-cycle bits starting cycle 11; `tx_busy` high cycles 11–90.
- TX buffering: writes 8'h01, 8'h02, 8'h03 on three consecutive cycles → 01 and 02 are sent with no gap; 03 is dropped; `tx_overrun`=1.
- RX good byte: drive 8'h3C frame on `uart_rx` → `rio_in`=8'h3C and `rx_valid`=1; `rx_ack` → `rx_valid`=0 next cycle with `rio_in` held.
- RX faults:
  - a 2-cycle low glitch → no state change;
  - a frame with stop=0 → one `rx_frame_err` pulse and `rio_in` unchanged.
- RX overrun: two frames 8'h11 then 8'h22 with no ack → `rio_in`=8'h22, `rx_overrun`=1; repeat with ack coincident with the second byte → `rx_overrun` stays 0.
- Reset mid-frame: assert `rst` during TX bit 3 and RX bit 4 → all outputs return to reset values at once; the next frames transmit and receive correctly.
